// File: rtl/fe_tx_rd_arbiter_pkg.sv
// Shared types and helpers for the TX frontend read-port arbiter.
// Lock FSM states plus index arithmetic used by the arbiter and its order FIFO.
package fe_tx_rd_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned rr_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fe_tx_rd_arbiter_if.sv
// Request/response bus between NUM_REQ TX frontends, the arbiter and the RAM read port.
// Requester-side signals are packed vectors; requester i owns slice i.
interface fe_tx_rd_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned AW         = 15,
    parameter int unsigned ID_WIDTH   = 5,
    parameter int unsigned DATA_WIDTH = 64
);
    logic [NUM_REQ*AW-1:0]       s_araddr;
    logic [NUM_REQ*ID_WIDTH-1:0] s_arid;
    logic [NUM_REQ-1:0]          s_arvalid;
    logic [NUM_REQ-1:0]          s_arready;
    logic [AW-1:0]               m_araddr;
    logic [ID_WIDTH-1:0]         m_arid;
    logic                        m_arvalid;
    logic                        m_arready;
    logic [DATA_WIDTH-1:0]       m_rdata;
    logic [ID_WIDTH-1:0]         m_rid;
    logic                        m_rvalid;
    logic                        m_rready;
    logic [DATA_WIDTH-1:0]       s_rdata;
    logic [ID_WIDTH-1:0]         s_rid;
    logic [NUM_REQ-1:0]          s_rvalid;
    logic [NUM_REQ-1:0]          s_rready;

    modport master (
        input  s_araddr, s_arid, s_arvalid, m_arready, m_rdata, m_rid, m_rvalid, s_rready,
        output s_arready, m_araddr, m_arid, m_arvalid, m_rready, s_rdata, s_rid, s_rvalid
    );

    modport slave (
        output s_araddr, s_arid, s_arvalid, m_arready, m_rdata, m_rid, m_rvalid, s_rready,
        input  s_arready, m_araddr, m_arid, m_arvalid, m_rready, s_rdata, s_rid, s_rvalid
    );
endinterface

// File: rtl/fe_tx_rd_arbiter_order_fifo.sv
// In-order tracking FIFO holding the requester index of every issued read.
// Push is ignored when full and pop when empty, so callers may drive them unguarded.
module fe_tx_rd_order_fifo
    import fe_tx_rd_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int unsigned PTR_W = idx_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/fe_tx_rd_arbiter.sv
// Burst-aware round-robin arbiter sharing one RAM read port among NUM_REQ TX frontends.
// AR and R paths are combinational; responses are routed back via the order FIFO.
module fe_tx_rd_arbiter
    import fe_tx_rd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned RAM_ADDR_WIDTH = 18,
    parameter int unsigned DATA_BITS      = 3,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ID_WIDTH       = 5,
    parameter int unsigned OUTSTANDING    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           cfg_enable,
    fe_tx_rd_arbiter_if.master           bus,
    output logic [$clog2(OUTSTANDING):0] stat_outstanding
);
    localparam int unsigned AW        = RAM_ADDR_WIDTH - DATA_BITS;
    localparam int unsigned REQ_IDX_W = idx_w(NUM_REQ);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [REQ_IDX_W-1:0] r_grant,    w_grant_nxt;
    logic [REQ_IDX_W-1:0] r_rr_ptr,   w_rr_ptr_nxt;
    logic [REQ_IDX_W-1:0] r_pend_idx, w_pend_idx_nxt;
    logic                 r_pend_vld, w_pend_vld_nxt;

    logic [AW-1:0]        w_addr [NUM_REQ];
    logic [ID_WIDTH-1:0]  w_id   [NUM_REQ];
    int unsigned          w_sum;
    logic [REQ_IDX_W-1:0] w_cand;
    logic [REQ_IDX_W-1:0] w_scan_idx;
    logic                 w_scan_hit;
    logic [REQ_IDX_W-1:0] w_sel_idx;
    logic                 w_has_sel;
    logic                 w_sel_vld;
    logic [REQ_IDX_W-1:0] w_rr_inc;
    logic                 w_ar_hs;
    logic                 w_r_hs;
    logic [REQ_IDX_W-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr[g] = bus.s_araddr[g*AW +: AW];
        assign w_id[g]   = bus.s_arid[g*ID_WIDTH +: ID_WIDTH];
    end

    // First enabled, valid requester at or after rr_ptr, with wrap.
    always_comb begin
        w_scan_hit = 1'b0;
        w_scan_idx = r_rr_ptr;
        w_sum      = 0;
        w_cand     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_sum = 32'(r_rr_ptr) + k;
            if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
            w_cand = REQ_IDX_W'(w_sum);
            if (!w_scan_hit && bus.s_arvalid[w_cand] && cfg_enable[w_cand]) begin
                w_scan_hit = 1'b1;
                w_scan_idx = w_cand;
            end
        end
    end

    // A stalled IDLE winner is held in pend so the presented request never switches;
    // rst_n gates selection so nothing is offered while the block is held in reset.
    always_comb begin
        w_has_sel = 1'b0;
        w_sel_idx = r_grant;
        if (r_state == ARB_LOCKED) begin
            w_has_sel = 1'b1;
            w_sel_idx = r_grant;
        end else if (r_pend_vld) begin
            w_has_sel = 1'b1;
            w_sel_idx = r_pend_idx;
        end else if (w_scan_hit) begin
            w_has_sel = 1'b1;
            w_sel_idx = w_scan_idx;
        end
        w_has_sel = w_has_sel && rst_n;
    end

    assign w_sel_vld = w_has_sel && bus.s_arvalid[w_sel_idx];
    assign w_ar_hs   = bus.m_arvalid && bus.m_arready;
    assign w_rr_inc  = REQ_IDX_W'(rr_inc(32'(w_sel_idx), NUM_REQ));

    always_comb begin
        bus.m_araddr  = w_addr[w_sel_idx];
        bus.m_arid    = w_id[w_sel_idx];
        bus.m_arvalid = w_sel_vld && !w_full;
        bus.s_arready = '0;
        if (w_has_sel) bus.s_arready[w_sel_idx] = bus.m_arready && !w_full;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_idx_nxt = r_pend_idx;
        case (r_state)
            ARB_IDLE: begin
                if (w_ar_hs) begin
                    w_pend_vld_nxt = 1'b0;
                    if (bus.m_arid[0]) begin
                        w_rr_ptr_nxt = w_rr_inc;
                    end else begin
                        w_state_nxt = ARB_LOCKED;
                        w_grant_nxt = w_sel_idx;
                    end
                end else if (bus.m_arvalid) begin
                    w_pend_vld_nxt = 1'b1;
                    w_pend_idx_nxt = w_sel_idx;
                end
            end
            ARB_LOCKED: begin
                if (w_ar_hs && bus.m_arid[0]) begin
                    w_state_nxt  = ARB_IDLE;
                    w_rr_ptr_nxt = w_rr_inc;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_pend_vld <= 1'b0;
            r_pend_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_idx <= w_pend_idx_nxt;
        end
    end

    always_comb begin
        bus.s_rvalid = '0;
        bus.m_rready = 1'b0;
        bus.s_rdata  = bus.m_rdata;
        bus.s_rid    = bus.m_rid;
        if (!w_empty) begin
            bus.s_rvalid[w_head] = bus.m_rvalid;
            bus.m_rready         = bus.s_rready[w_head];
        end
    end

    assign w_r_hs = bus.m_rvalid && bus.m_rready;

    fe_tx_rd_order_fifo #(
        .WIDTH (REQ_IDX_W),
        .DEPTH (OUTSTANDING)
    ) u_order_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_ar_hs),
        .i_push_data (w_sel_idx),
        .i_pop       (w_r_hs),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (stat_outstanding)
    );

endmodule

// File: tb/tb_fe_tx_rd_arbiter.sv
// Scoreboard bench for fe_tx_rd_arbiter: directed requests with hand-ordered expected
// grants and response routing, checked by independent AR and R monitors.
module tb_fe_tx_rd_arbiter;
    localparam int unsigned NUM_REQ  = 2;
    localparam int unsigned AW       = 15;
    localparam int unsigned ID_WIDTH = 5;
    localparam int unsigned DW       = 64;
    localparam int unsigned EW       = AW + ID_WIDTH;

    logic       clk;
    logic       rst_n;
    logic [1:0] cfg_enable;
    logic [2:0] stat_outstanding;

    int n_tests = 0;
    int n_fail  = 0;

    logic [EW-1:0] q0[$];
    logic [EW-1:0] q1[$];
    logic [EW:0]   exp_ar[$];
    logic [1:0]    exp_r[$];

    fe_tx_rd_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DW)) bus();

    fe_tx_rd_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .RAM_ADDR_WIDTH (18),
        .DATA_BITS      (3),
        .DATA_WIDTH     (DW),
        .ID_WIDTH       (ID_WIDTH),
        .OUTSTANDING    (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_enable       (cfg_enable),
        .bus              (bus),
        .stat_outstanding (stat_outstanding)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_grant(input logic req, input logic [AW-1:0] addr, input logic [ID_WIDTH-1:0] id);
        exp_ar.push_back({req, addr, id});
    endtask

    task automatic wait_ar_done();
        int b = 0;
        while (exp_ar.size() != 0 && b < 200) begin
            @(negedge clk);
            b++;
        end
        check("ar_drain", 64'(exp_ar.size()), 0);
        tick(1);
    endtask

    task automatic respond(input int n);
        int got = 0;
        int b = 0;
        bus.m_rvalid = 1'b1;
        bus.s_rready = 2'b11;
        while (got < n && b < 200) begin
            @(negedge clk);
            if (bus.m_rready) got++;
            b++;
            tick(1);
            bus.m_rdata = bus.m_rdata + 64'h1111;
        end
        bus.m_rvalid = 1'b0;
        bus.s_rready = '0;
        check("r_count", 64'(got), 64'(n));
    endtask

    // Requester drivers: present queue heads, advance on observed handshakes.
    initial begin : drv
        logic [1:0] hs;
        bus.s_arvalid = '0;
        bus.s_araddr  = '0;
        bus.s_arid    = '0;
        forever begin
            @(negedge clk);
            hs = bus.s_arvalid & bus.s_arready;
            @(posedge clk);
            #1;
            if (hs[0] && q0.size() > 0) void'(q0.pop_front());
            if (hs[1] && q1.size() > 0) void'(q1.pop_front());
            bus.s_arvalid = {q1.size() > 0, q0.size() > 0};
            if (q0.size() > 0) {bus.s_araddr[AW-1:0], bus.s_arid[ID_WIDTH-1:0]} = q0[0];
            if (q1.size() > 0) {bus.s_araddr[2*AW-1:AW], bus.s_arid[2*ID_WIDTH-1:ID_WIDTH]} = q1[0];
        end
    end

    initial begin : ar_mon
        logic [EW:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.m_arvalid && bus.m_arready) begin
                if (exp_ar.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ar_unexpected actual=%0h required=none", bus.m_araddr);
                end else begin
                    e = exp_ar.pop_front();
                    check("ar_addr", 64'(bus.m_araddr), 64'(e[EW-1:ID_WIDTH]));
                    check("ar_id", 64'(bus.m_arid), 64'(e[ID_WIDTH-1:0]));
                    check("ar_ready_onehot", 64'(bus.s_arready), e[EW] ? 64'h2 : 64'h1);
                end
            end
        end
    end

    initial begin : r_mon
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.m_rvalid && bus.m_rready) begin
                if (exp_r.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL r_unexpected actual=%0h required=none", bus.s_rvalid);
                end else begin
                    e = exp_r.pop_front();
                    check("r_valid_onehot", 64'(bus.s_rvalid), 64'(e));
                    check("r_data", bus.s_rdata, bus.m_rdata);
                    check("r_id", 64'(bus.s_rid), 64'(bus.m_rid));
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        cfg_enable   = 2'b11;
        bus.m_arready = 1'b1;
        bus.m_rvalid  = 1'b0;
        bus.s_rready  = '0;
        bus.m_rdata   = 64'hA5A5_0000_0000_0001;
        bus.m_rid     = 5'h11;

        // Reset with both requesters valid, then round-robin single beats
        q0.push_back({15'h100, 5'h01}); q0.push_back({15'h101, 5'h03});
        q1.push_back({15'h200, 5'h01}); q1.push_back({15'h201, 5'h05});
        exp_grant(0, 15'h100, 5'h01); exp_grant(1, 15'h200, 5'h01);
        exp_grant(0, 15'h101, 5'h03); exp_grant(1, 15'h201, 5'h05);
        exp_r.push_back(2'b01); exp_r.push_back(2'b10);
        exp_r.push_back(2'b01); exp_r.push_back(2'b10);
        tick(3);
        @(negedge clk);
        check("rst_s_arready", 64'(bus.s_arready), 0);
        check("rst_m_arvalid", 64'(bus.m_arvalid), 0);
        check("rst_stat", 64'(stat_outstanding), 0);
        check("rst_s_rvalid", 64'(bus.s_rvalid), 0);
        tick(1);
        rst_n = 1'b1;
        wait_ar_done();
        check("rr_stat_full", 64'(stat_outstanding), 4);
        check("rr_arvalid_full", 64'(bus.m_arvalid), 0);
        respond(4);
        check("rr_stat_empty", 64'(stat_outstanding), 0);

        // Burst lock: 4-beat burst from requester 0 while requester 1 waits
        q0.push_back({15'h300, 5'h02}); q0.push_back({15'h301, 5'h02});
        q0.push_back({15'h302, 5'h02}); q0.push_back({15'h303, 5'h03});
        q1.push_back({15'h400, 5'h01});
        exp_grant(0, 15'h300, 5'h02); exp_grant(0, 15'h301, 5'h02);
        exp_grant(0, 15'h302, 5'h02); exp_grant(0, 15'h303, 5'h03);
        exp_grant(1, 15'h400, 5'h01);
        repeat (4) exp_r.push_back(2'b01);
        exp_r.push_back(2'b10);
        respond(5);
        wait_ar_done();

        // Order FIFO full: six requests, four accepted, then one per freed slot
        q0.push_back({15'h500, 5'h01}); q0.push_back({15'h501, 5'h01}); q0.push_back({15'h502, 5'h01});
        q1.push_back({15'h600, 5'h01}); q1.push_back({15'h601, 5'h01}); q1.push_back({15'h602, 5'h01});
        exp_grant(0, 15'h500, 5'h01); exp_grant(1, 15'h600, 5'h01);
        exp_grant(0, 15'h501, 5'h01); exp_grant(1, 15'h601, 5'h01);
        exp_r.push_back(2'b01); exp_r.push_back(2'b10);
        exp_r.push_back(2'b01); exp_r.push_back(2'b10);
        wait_ar_done();
        tick(2);
        check("full_stat", 64'(stat_outstanding), 4);
        check("full_arvalid", 64'(bus.m_arvalid), 0);
        check("full_s_arready", 64'(bus.s_arready), 0);
        exp_grant(0, 15'h502, 5'h01);
        exp_r.push_back(2'b01);
        respond(1);
        wait_ar_done();
        tick(2);
        check("refill_stat", 64'(stat_outstanding), 4);
        check("refill_arvalid", 64'(bus.m_arvalid), 0);
        exp_grant(1, 15'h602, 5'h01);
        exp_r.push_back(2'b10);
        respond(5);
        wait_ar_done();
        check("full_drain_stat", 64'(stat_outstanding), 0);

        // Response routing for issue order 1,0,1 and head-of-line stall
        q1.push_back({15'h700, 5'h01}); exp_grant(1, 15'h700, 5'h01); wait_ar_done();
        q0.push_back({15'h710, 5'h01}); exp_grant(0, 15'h710, 5'h01); wait_ar_done();
        q1.push_back({15'h701, 5'h01}); exp_grant(1, 15'h701, 5'h01); wait_ar_done();
        exp_r.push_back(2'b10); exp_r.push_back(2'b01); exp_r.push_back(2'b10);
        check("route_stat", 64'(stat_outstanding), 3);
        bus.m_rvalid = 1'b1;
        bus.s_rready = 2'b01;
        @(negedge clk);
        check("stall_m_rready", 64'(bus.m_rready), 0);
        check("stall_s_rvalid", 64'(bus.s_rvalid), 2'b10);
        tick(1);
        @(negedge clk);
        check("stall_stat", 64'(stat_outstanding), 3);
        tick(1);
        respond(3);

        // cfg_enable dropped mid-burst does not break requester 1's lock
        q1.push_back({15'h800, 5'h02}); q1.push_back({15'h801, 5'h02});
        q1.push_back({15'h802, 5'h02}); q1.push_back({15'h803, 5'h03});
        exp_grant(1, 15'h800, 5'h02); exp_grant(1, 15'h801, 5'h02);
        exp_grant(1, 15'h802, 5'h02); exp_grant(1, 15'h803, 5'h03);
        repeat (4) exp_r.push_back(2'b10);
        fork
            respond(5);
            begin
                int b = 0;
                while (exp_ar.size() > 3 && b < 100) begin
                    @(negedge clk);
                    b++;
                end
                @(posedge clk);
                #1;
                cfg_enable = 2'b01;
                q0.push_back({15'h810, 5'h01});
                exp_grant(0, 15'h810, 5'h01);
                exp_r.push_back(2'b01);
            end
        join
        wait_ar_done();

        // Disabled requester 1 is skipped until re-enabled
        q0.push_back({15'h811, 5'h01}); q0.push_back({15'h812, 5'h01});
        q1.push_back({15'h820, 5'h01});
        exp_grant(0, 15'h811, 5'h01); exp_grant(0, 15'h812, 5'h01);
        wait_ar_done();
        tick(3);
        check("dis_arvalid", 64'(bus.m_arvalid), 0);
        check("dis_s_arready", 64'(bus.s_arready), 0);
        check("dis_stat", 64'(stat_outstanding), 2);
        exp_grant(1, 15'h820, 5'h01);
        exp_r.push_back(2'b01); exp_r.push_back(2'b01); exp_r.push_back(2'b10);
        cfg_enable = 2'b11;
        wait_ar_done();
        respond(3);

        // Stalled IDLE winner is held while a higher-priority requester appears
        bus.m_arready = 1'b0;
        q1.push_back({15'h910, 5'h01});
        tick(3);
        @(negedge clk);
        check("pend_arvalid", 64'(bus.m_arvalid), 1);
        check("pend_addr_first", 64'(bus.m_araddr), 15'h910);
        tick(1);
        q0.push_back({15'h900, 5'h01});
        tick(3);
        @(negedge clk);
        check("pend_addr_hold", 64'(bus.m_araddr), 15'h910);
        tick(1);
        exp_grant(1, 15'h910, 5'h01); exp_grant(0, 15'h900, 5'h01);
        exp_r.push_back(2'b10); exp_r.push_back(2'b01);
        bus.m_arready = 1'b1;
        wait_ar_done();
        respond(2);

        tick(2);
        check("final_exp_ar_empty", 64'(exp_ar.size()), 0);
        check("final_exp_r_empty", 64'(exp_r.size()), 0);
        check("final_stat", 64'(stat_outstanding), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
